// File: rtl/freq_meter_pkg.sv
// Purpose: shared constants and FSM state type for the gated frequency meter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// System-clock figures live here so that the meter and the clock dividers
// agree on what "one second" means.
package freq_meter_pkg;

  localparam int SYS_CLK_HZ      = 100_000_000;
  localparam int DEF_GATE_CYCLES = SYS_CLK_HZ;   // 1 s window at SYS_CLK_HZ
  localparam int DEF_GATE_W      = 27;           // 2**27 > 100e6
  localparam int DEF_CNT_W       = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GATE  = 2'd1,
    LATCH = 2'd2
  } state_t;

endpackage

// File: rtl/freq_meter_if.sv
// Purpose: control/result bundle between a meter client and freq_meter.
// Latency: n/a (wires only).
// Backpressure: none; valid is a one-cycle strobe, results hold until the next one.
//
// Signals: start/cont (client -> meter), busy/valid/freq_count/overflow
// (meter -> client).
interface freq_meter_if
  import freq_meter_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             start;
  logic             cont;
  logic             busy;
  logic             valid;
  logic             overflow;
  logic [CNT_W-1:0] freq_count;

  modport master (
    output start, cont,
    input  busy, valid, overflow, freq_count
  );

  modport slave (
    input  start, cont,
    output busy, valid, overflow, freq_count
  );

endinterface

// File: rtl/freq_meter_sync_edge_det.sv
// Purpose: 2-flop synchronizer plus rising-edge pulse for an asynchronous input.
// Latency: rise is high in the cycle after the second clk_in edge that sees d=1.
// Backpressure: none; one rise pulse per synchronized 0->1 transition.
//
// Ports: clk_in (clock), rst_n (async active-low reset), d (async input),
// rise (one-cycle pulse in the clk_in domain).
module sync_edge_det (
  input  logic clk_in,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic sync1_q;
  logic sync2_q;
  logic sync_d_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sync_d_q <= 1'b0;
    end else begin
      sync1_q  <= d;
      sync2_q  <= sync1_q;
      sync_d_q <= sync2_q;
    end
  end

  assign rise = sync2_q & ~sync_d_q;

endmodule

// File: rtl/freq_meter.sv
// Purpose: counts rising edges of sig_in over a window of GATE_CYCLES clk_in cycles.
// Latency: result and valid appear in the cycle after the last gate cycle;
//          an edge on sig_in reaches the counter 3 clk_in edges later.
// Backpressure: none; start while busy is dropped, results hold until the next valid.
//
// Ports: clk_in, rst_n (async active-low), sig_in (async signal under test),
// bus (slave side of freq_meter_if: start, cont, busy, valid, freq_count, overflow).
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int GATE_W      = DEF_GATE_W,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       sig_in,
  freq_meter_if.slave bus
);

  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic              rise;
  state_t            state_q;
  logic [GATE_W-1:0] gate_cnt_q;
  logic [CNT_W-1:0]  edge_cnt_q;
  logic [CNT_W-1:0]  edge_cnt_d;
  logic              ovf_q;
  logic              ovf_d;
  logic [CNT_W-1:0]  freq_count_q;
  logic              overflow_q;
  logic              valid_q;
  logic              busy_q;

  sync_edge_det u_sync (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .d      (sig_in),
    .rise   (rise)
  );

  // Saturating edge count; a rise that arrives at saturation marks the gate
  // as overflowed instead of wrapping.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    ovf_d      = ovf_q;
    if (rise) begin
      if (edge_cnt_q == CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        edge_cnt_d = edge_cnt_q + 1'b1;
      end
    end
  end

  // The result registers load on the last gate edge (including that cycle's
  // rise) so freq_count/overflow are already updated while valid is high in LATCH.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gate_cnt_q   <= '0;
      edge_cnt_q   <= '0;
      ovf_q        <= 1'b0;
      freq_count_q <= '0;
      overflow_q   <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start || bus.cont) begin
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= GATE;
          end
        end
        GATE: begin
          gate_cnt_q <= gate_cnt_q + 1'b1;
          edge_cnt_q <= edge_cnt_d;
          ovf_q      <= ovf_d;
          if (gate_cnt_q == GATE_LAST) begin
            freq_count_q <= edge_cnt_d;
            overflow_q   <= ovf_d;
            valid_q      <= 1'b1;
            state_q      <= LATCH;
          end
        end
        LATCH: begin
          // Edges during this dead cycle are dropped by the counter clear.
          if (bus.cont) begin
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            ovf_q      <= 1'b0;
            state_q    <= GATE;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.valid      = valid_q;
  assign bus.overflow   = overflow_q;
  assign bus.freq_count = freq_count_q;

endmodule

// File: tb/tb_freq_meter.sv
// Purpose: self-checking bench for freq_meter with GATE_CYCLES=100 at CNT_W=8 and CNT_W=4.
// Latency: n/a.
// Backpressure: n/a.
module tb_freq_meter;

  localparam int GC = 100;

  logic clk = 1'b0;
  logic rst_n;
  logic sig_in;
  logic start_r;
  logic cont_r;
  logic sig_lvl;
  logic sig_gen;
  int   sig_half;
  int   ph;

  int checks   = 0;
  int failures = 0;
  int vcount   = 0;
  int busy_tot = 0;

  always #5 clk = ~clk;

  freq_meter_if #(.CNT_W(8)) bus8 ();
  freq_meter_if #(.CNT_W(4)) bus4 ();

  assign bus8.start = start_r;
  assign bus8.cont  = cont_r;
  assign bus4.start = start_r;
  assign bus4.cont  = cont_r;

  freq_meter #(.GATE_CYCLES(GC), .GATE_W(7), .CNT_W(8)) u_dut8 (
    .clk_in (clk),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .bus    (bus8)
  );

  freq_meter #(.GATE_CYCLES(GC), .GATE_W(7), .CNT_W(4)) u_dut4 (
    .clk_in (clk),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .bus    (bus4)
  );

  // Square-wave source: half-period sig_half clk cycles, or a constant level.
  always @(negedge clk) begin
    if (sig_half == 0) begin
      ph      = 0;
      sig_gen = 1'b0;
    end else begin
      ph = ph + 1;
      if (ph >= sig_half) begin
        ph      = 0;
        sig_gen = ~sig_gen;
      end
    end
  end
  assign sig_in = (sig_half != 0) ? sig_gen : sig_lvl;

  task automatic chk(input string nm, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Window model: a 0->1 level seen at clock edge N is attributed to edge N+2.
  // A measurement accepted at edge S owns edges S+1..S+GC; the result is shown
  // for the one dead cycle that follows, and cont at that dead edge restarts.
  bit h0, h1, h2;
  bit m_active, m_busy, m_valid;
  int m_left, m_n;
  int m_f8, m_o8, m_f4, m_o4;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h0 = 0; h1 = 0; h2 = 0;
      m_active = 0; m_busy = 0; m_valid = 0;
      m_left = 0; m_n = 0;
      m_f8 = 0; m_o8 = 0; m_f4 = 0; m_o4 = 0;
    end else begin
      bit rise_now;
      rise_now = h1 & ~h2;
      h2 = h1; h1 = h0; h0 = sig_in;
      m_valid = 0;
      if (!m_active) begin
        if (start_r || cont_r) begin
          m_active = 1; m_left = GC; m_n = 0;
        end
      end else if (m_left > 0) begin
        if (rise_now) m_n = m_n + 1;
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_valid = 1;
          m_f8 = (m_n > 255) ? 255 : m_n;
          m_o8 = (m_n > 255) ? 1 : 0;
          m_f4 = (m_n > 15) ? 15 : m_n;
          m_o4 = (m_n > 15) ? 1 : 0;
        end
      end else begin
        if (cont_r) begin
          m_left = GC; m_n = 0;
        end else begin
          m_active = 0;
        end
      end
      m_busy = m_active;
    end
  end

  // Cycle-by-cycle comparison of both DUTs against the model.
  always @(posedge clk) begin
    #2;
    chk("busy8",  int'(bus8.busy),       int'(m_busy));
    chk("valid8", int'(bus8.valid),      int'(m_valid));
    chk("freq8",  int'(bus8.freq_count), m_f8);
    chk("ovf8",   int'(bus8.overflow),   m_o8);
    chk("busy4",  int'(bus4.busy),       int'(m_busy));
    chk("valid4", int'(bus4.valid),      int'(m_valid));
    chk("freq4",  int'(bus4.freq_count), m_f4);
    chk("ovf4",   int'(bus4.overflow),   m_o4);
    if (bus8.valid) vcount = vcount + 1;
    if (bus8.busy) busy_tot = busy_tot + 1;
  end

  task automatic wait_valid(input int limit);
    bit found;
    found = 0;
    for (int i = 0; i < limit && !found; i++) begin
      @(posedge clk);
      #3;
      if (bus8.valid) found = 1;
    end
    chk("valid_seen", int'(found), 1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_single();
    @(negedge clk); start_r = 1'b1;
    @(negedge clk); start_r = 1'b0;
    wait_valid(300);
  endtask

  // Start a gate, then raise sig_lvl at the j-th following negedge.
  task automatic start_and_rise(input int j);
    @(negedge clk); start_r = 1'b1;
    for (int i = 1; i <= j; i++) begin
      @(negedge clk);
      if (i == 1) start_r = 1'b0;
    end
    sig_lvl = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int v0, b0;
    rst_n = 1'b0; start_r = 1'b0; cont_r = 1'b0;
    sig_lvl = 1'b0; sig_half = 0; sig_gen = 1'b0; ph = 0;
    idle_cycles(3);
    #1;
    chk("rst_busy",  int'(bus8.busy),       0);
    chk("rst_valid", int'(bus8.valid),      0);
    chk("rst_freq",  int'(bus8.freq_count), 0);
    chk("rst_ovf",   int'(bus8.overflow),   0);
    @(negedge clk); rst_n = 1'b1;

    // 1. nominal, period 10
    sig_half = 5; idle_cycles(20);
    v0 = vcount; b0 = busy_tot;
    run_single();
    chk("nom_freq8", int'(bus8.freq_count), 10);
    chk("nom_ovf8",  int'(bus8.overflow),   0);
    idle_cycles(10);
    chk("nom_busy_len", busy_tot - b0, 101);
    chk("nom_nvalid",   vcount - v0,   1);

    // 2. constant levels
    sig_half = 0; sig_lvl = 1'b1; idle_cycles(10);
    run_single();
    chk("const1_freq8", int'(bus8.freq_count), 0);
    sig_lvl = 1'b0; idle_cycles(10);
    run_single();
    chk("const0_freq8", int'(bus8.freq_count), 0);

    // 3. continuous, period 4
    sig_half = 2; idle_cycles(10);
    @(negedge clk); cont_r = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_valid(300);
      chk("cont_freq8", int'(bus8.freq_count), 25);
    end
    idle_cycles(50);
    cont_r = 1'b0;
    v0 = vcount;
    wait_valid(300);
    chk("cont_last_freq8", int'(bus8.freq_count), 25);
    idle_cycles(150);
    chk("cont_tail_nvalid", vcount - v0, 1);
    chk("cont_tail_busy",   int'(bus8.busy), 0);

    // 4. saturation at CNT_W=4, then recovery
    sig_half = 1; idle_cycles(10);
    run_single();
    chk("sat_freq4", int'(bus4.freq_count), 15);
    chk("sat_ovf4",  int'(bus4.overflow),   1);
    chk("sat_freq8", int'(bus8.freq_count), 50);
    chk("sat_ovf8",  int'(bus8.overflow),   0);
    sig_half = 10; idle_cycles(10);
    run_single();
    chk("rec_freq4", int'(bus4.freq_count), 5);
    chk("rec_ovf4",  int'(bus4.overflow),   0);

    // 5. boundary: rise reaching the last gate edge vs. the dead edge
    sig_half = 0; sig_lvl = 1'b0; idle_cycles(10);
    start_and_rise(98);
    wait_valid(300);
    chk("bnd_last_freq8", int'(bus8.freq_count), 1);
    sig_lvl = 1'b0; idle_cycles(10);
    start_and_rise(99);
    wait_valid(300);
    chk("bnd_latch_freq8", int'(bus8.freq_count), 0);

    // 6. reset mid-gate, then start pulses while busy
    sig_lvl = 1'b0; sig_half = 5; idle_cycles(10);
    run_single();
    chk("pre_rst_freq8", int'(bus8.freq_count), 10);
    idle_cycles(5);
    @(negedge clk); start_r = 1'b1;
    @(negedge clk); start_r = 1'b0;
    idle_cycles(49);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",  int'(bus8.busy),       0);
    chk("mid_rst_freq",  int'(bus8.freq_count), 0);
    chk("mid_rst_valid", int'(bus8.valid),      0);
    v0 = vcount;
    idle_cycles(3);
    rst_n = 1'b1;
    idle_cycles(200);
    chk("post_rst_nvalid", vcount - v0, 0);

    v0 = vcount;
    @(negedge clk); start_r = 1'b1;
    @(negedge clk); start_r = 1'b0;
    idle_cycles(19); start_r = 1'b1;
    @(negedge clk);  start_r = 1'b0;
    idle_cycles(39); start_r = 1'b1;
    @(negedge clk);  start_r = 1'b0;
    wait_valid(300);
    chk("ign_freq8", int'(bus8.freq_count), 10);
    idle_cycles(200);
    chk("ign_nvalid", vcount - v0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
Gated frequency counter that measures the slow clock produced by our clock dividers (or any slow external square wave) against the system clock.
- Counts rising edges of an asynchronous input over a fixed window of GATE_CYCLES system clocks.
- Publishes the count with a one-cycle valid strobe.
- Used in bring-up and self-test to confirm divider outputs; supports single-shot and continuous operation.

Parameters:
- GATE_CYCLES, 100_000_000: gate window length in clk_in cycles (1 s at 100 MHz); must be >= 2.
- GATE_W, 27: gate counter width; must satisfy 2**GATE_W >= GATE_CYCLES.
- CNT_W, 32: edge counter and result width.

Ports:
- clk_in, input, 1: system clock; all logic on its rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- sig_in, input, 1: signal under measurement, asynchronous to clk_in.
- start, input, 1: request one measurement; sampled in IDLE only.
- cont, input, 1: when 1, a new gate starts immediately after each result.
- busy, output, 1: 1 while in GATE or LATCH.
- freq_count, output, CNT_W: rising edges counted in the last completed gate.
- valid, output, 1: one-cycle strobe when freq_count updates.
- overflow, output, 1: edge counter saturated during the last completed gate.

Behaviour:
- Reset (async assert, sync release effect):
  - state=IDLE; gate_cnt, edge_cnt, freq_count = 0.
  - valid, overflow, busy = 0.
  - Synchronizer and edge-detect flops = 0.
- Input path:
  - 2-flop synchronizer, then a delay flop.
  - rise = sync2 & ~sync_d.
  - An edge at sig_in is counted 3 clk_in cycles later.
  - Maximum measurable input frequency is f_clk/2 after synchronization.
- FSM states: IDLE, GATE, LATCH.
- IDLE:
  - busy=0.
  - If start=1 or cont=1: clear gate_cnt and edge_cnt, go to GATE next cycle.
- GATE:
  - busy=1; gate_cnt increments each cycle; edge_cnt increments on rise.
  - edge_cnt saturates at 2**CNT_W-1; the sticky internal ovf flag is set when rise occurs at saturation.
  - When gate_cnt == GATE_CYCLES-1 (that cycle's rise is still counted): go to LATCH.
  - The window is exactly GATE_CYCLES cycles.
- LATCH, one cycle:
  - freq_count <= edge_cnt; overflow <= ovf; valid=1 for this cycle only.
  - If cont=1: clear counters and ovf, return to GATE. Back-to-back gates have a 1-cycle dead time; edges in LATCH are discarded.
  - Else: go to IDLE.
- start while busy is ignored, with no queuing.
- cont deasserted during GATE: the current gate completes, then IDLE.
- freq_count and overflow hold their value until the next LATCH. They are not cleared by start.
- Reset mid-gate aborts the measurement. All outputs return to reset values and no valid is issued.
- sig_in stuck high or low: count = 0 (a constant level is not an edge); valid is still issued.
- Counter widths: gate_cnt compares against GATE_CYCLES-1 at GATE_W bits; no wrap is possible given the parameter rule.

Decomposition:
- Shared package (freq_meter_pkg):
  - State encoding constants IDLE=2'd0, GATE=2'd1, LATCH=2'd2.
  - Default GATE_CYCLES and width constants, shared with the divider defaults so that system clock figures agree.
- One natural sub-module: sync_edge_det (2-flop synchronizer plus rising-edge pulse, async active-low reset, ports clk_in/rst_n/d/rise). It is reusable for other asynchronous inputs.
- The FSM and counters stay in freq_meter.

Test Plan:
Benches run with GATE_CYCLES=100, CNT_W=8.
1. Nominal: sig_in period 10 clk, single start → busy 100+1 cycles, one valid pulse, freq_count=10, overflow=0.
2. Constant input: sig_in held 1, start → valid, freq_count=0; repeat with sig_in=0 → freq_count=0.
3. Continuous: cont=1, sig_in period 4 → valid every 101 cycles, each freq_count=25 (±1 at phase boundaries), busy never drops; cont→0 mid-gate → exactly one more valid, then IDLE.
4. Saturation: CNT_W=4, sig_in period 2 → freq_count=15, overflow=1; next gate with period 20 → freq_count=5, overflow=0.
5. Boundary: single sig_in rise timed so that its synchronized pulse lands on the last gate cycle → counted (freq_count=1); rise landing in LATCH → not counted.
6. Reset/robustness: rst_n low at gate cycle 50 → outputs 0 immediately (async), no valid; start pulses during GATE → ignored, only one valid.
